// File: rtl/goertzel_pkg.sv
// Shared types and default widths for the Goertzel tone detector.
package goertzel_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SQRE,
        S_SQIM,
        S_DEC
    } state_t;

    localparam int GZ_IW = 18;
    localparam int GZ_PW = 2 * GZ_IW;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/tone_hysteresis.sv
// Debounced tone-present flag: N_ON consecutive hits to assert, N_OFF
// consecutive misses to release, with a dead band between TH_OFF and TH_ON.
module tone_hysteresis
    import goertzel_pkg::*;
#(
    parameter int             PW     = GZ_PW,
    parameter logic [PW-1:0]  TH_ON  = 36'd1000000,
    parameter logic [PW-1:0]  TH_OFF = 36'd500000,
    parameter int             N_ON   = 3,
    parameter int             N_OFF  = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    input  logic [PW-1:0] i_power,
    output logic          o_tone
);

    localparam int CW = clog2_f((N_ON > N_OFF) ? N_ON : N_OFF) + 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          hit;
    logic          miss;

    assign cnt_inc = cnt + 1'b1;
    assign hit     = (i_power >= TH_ON);
    assign miss    = (i_power <  TH_OFF);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt    <= '0;
            o_tone <= 1'b0;
        end else if (i_valid) begin
            if (!o_tone) begin
                if (!hit) begin
                    cnt <= '0;
                end else if (cnt_inc == CW'(N_ON)) begin
                    o_tone <= 1'b1;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end else begin
                // dead-band power counts as a non-miss and restarts the run
                if (!miss) begin
                    cnt <= '0;
                end else if (cnt_inc == CW'(N_OFF)) begin
                    o_tone <= 1'b0;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: rtl/goertzel_tone_detect.sv
// Bin power Re^2+Im^2 through one shared multiplier, then hysteresis tone flag.
module goertzel_tone_detect
    import goertzel_pkg::*;
#(
    parameter int             IW     = GZ_IW,
    parameter int             PW     = 2 * IW,
    parameter logic [PW-1:0]  TH_ON  = 36'd1000000,
    parameter logic [PW-1:0]  TH_OFF = 36'd500000,
    parameter int             N_ON   = 3,
    parameter int             N_OFF  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic signed [IW-1:0] i_re,
    input  logic signed [IW-1:0] i_im,
    output logic [PW-1:0]        o_power,
    output logic                 o_power_valid,
    output logic                 o_tone,
    output logic                 o_busy,
    output logic                 o_overrun
);

    state_t               state;
    logic signed [IW-1:0] re_q;
    logic signed [IW-1:0] im_q;
    logic [PW-1:0]        acc;
    logic signed [IW-1:0] mul_a;
    logic signed [PW-1:0] prod;

    // Single squarer: Re in S_SQRE, Im in S_SQIM
    assign mul_a = (state == S_SQIM) ? im_q : re_q;
    assign prod  = mul_a * mul_a;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            re_q          <= '0;
            im_q          <= '0;
            acc           <= '0;
            o_power       <= '0;
            o_power_valid <= 1'b0;
            o_busy        <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            o_power_valid <= 1'b0;
            o_overrun     <= i_valid && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        re_q   <= i_re;
                        im_q   <= i_im;
                        state  <= S_SQRE;
                        o_busy <= 1'b1;
                    end
                end
                S_SQRE: begin
                    acc   <= prod;
                    state <= S_SQIM;
                end
                S_SQIM: begin
                    o_power       <= acc + prod;
                    o_power_valid <= 1'b1;
                    state         <= S_DEC;
                end
                S_DEC: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Decision runs in S_DEC, the one cycle o_power_valid is high
    tone_hysteresis #(
        .PW     (PW),
        .TH_ON  (TH_ON),
        .TH_OFF (TH_OFF),
        .N_ON   (N_ON),
        .N_OFF  (N_OFF)
    ) u_hyst (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (o_power_valid),
        .i_power (o_power),
        .o_tone  (o_tone)
    );

endmodule

// File: tb/tb_goertzel_tone_detect.sv
// Directed bench for goertzel_tone_detect with hand-computed powers.
module tb_goertzel_tone_detect;

    logic               i_clk;
    logic               i_rst_n;
    logic               i_valid;
    logic signed [17:0] i_re;
    logic signed [17:0] i_im;
    logic [35:0]        o_power;
    logic               o_power_valid;
    logic               o_tone;
    logic               o_busy;
    logic               o_overrun;

    int n_cmp = 0;
    int n_err = 0;

    goertzel_tone_detect dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .i_re          (i_re),
        .i_im          (i_im),
        .o_power       (o_power),
        .o_power_valid (o_power_valid),
        .o_tone        (o_tone),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Full frame: strobe, then check each of the following three edges.
    task automatic frame(input string tag, input logic signed [17:0] re,
                         input logic signed [17:0] im, input logic [35:0] exp_p,
                         input logic exp_tone);
        i_valid = 1'b1;
        i_re    = re;
        i_im    = im;
        tick();
        i_valid = 1'b0;
        chk({tag, "_busy0"}, 64'(o_busy), 64'd1);
        tick();
        chk({tag, "_pv_e1"}, 64'(o_power_valid), 64'd0);
        tick();
        chk({tag, "_pv_e2"}, 64'(o_power_valid), 64'd1);
        chk({tag, "_pwr"}, 64'(o_power), 64'(exp_p));
        tick();
        chk({tag, "_pv_e3"}, 64'(o_power_valid), 64'd0);
        chk({tag, "_busy3"}, 64'(o_busy), 64'd0);
        chk({tag, "_tone"}, 64'(o_tone), 64'(exp_tone));
    endtask

    initial begin
        int busy_cyc;
        int pv_cyc;
        int ovr_cyc;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_re    = '0;
        i_im    = '0;
        repeat (2) tick();
        chk("rst_power", 64'(o_power), 64'd0);
        chk("rst_pv", 64'(o_power_valid), 64'd0);
        chk("rst_tone", 64'(o_tone), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_ovr", 64'(o_overrun), 64'd0);
        i_rst_n = 1'b1;
        tick();

        frame("p25", 18'sd3, 18'sd4, 36'd25, 1'b0);
        frame("pmin", -18'sd131072, -18'sd131072, 36'd34359738368, 1'b0);
        frame("pmax", 18'sd131071, 18'sd0, 36'd17179607041, 1'b0);
        // zero power breaks the two-hit run left by the large frames
        frame("pzero", 18'sd0, 18'sd0, 36'd0, 1'b0);

        frame("on_a", 18'sd1000, 18'sd0, 36'd1000000, 1'b0);
        frame("on_gap", 18'sd0, 18'sd0, 36'd0, 1'b0);
        frame("on_b", 18'sd1000, 18'sd0, 36'd1000000, 1'b0);
        frame("on_c", 18'sd1000, 18'sd1000, 36'd2000000, 1'b0);
        frame("on_d", 18'sd1200, 18'sd0, 36'd1440000, 1'b1);

        frame("off_a", 18'sd632, 18'sd0, 36'd399424, 1'b1);
        frame("off_mid", 18'sd836, 18'sd0, 36'd698896, 1'b1);
        frame("off_b", 18'sd632, 18'sd0, 36'd399424, 1'b1);
        frame("off_c", 18'sd316, 18'sd0, 36'd99856, 1'b0);

        // overrun: second strobe lands on E2 while in S_SQIM
        busy_cyc = 0;
        pv_cyc   = 0;
        ovr_cyc  = 0;
        i_valid = 1'b1;
        i_re    = 18'sd5;
        i_im    = 18'sd12;
        tick();
        i_valid = 1'b0;
        busy_cyc += int'(o_busy);
        tick();
        busy_cyc += int'(o_busy);
        i_valid = 1'b1;
        i_re    = 18'sd100;
        i_im    = 18'sd100;
        tick();
        i_valid = 1'b0;
        chk("ovr_pulse", 64'(o_overrun), 64'd1);
        chk("ovr_pwr", 64'(o_power), 64'd169);
        busy_cyc += int'(o_busy);
        pv_cyc   += int'(o_power_valid);
        ovr_cyc  += int'(o_overrun);
        for (int k = 0; k < 5; k++) begin
            tick();
            busy_cyc += int'(o_busy);
            pv_cyc   += int'(o_power_valid);
            ovr_cyc  += int'(o_overrun);
        end
        chk("ovr_busy_cyc", 64'(busy_cyc), 64'd3);
        chk("ovr_pv_cyc", 64'(pv_cyc), 64'd1);
        chk("ovr_ovr_cyc", 64'(ovr_cyc), 64'd1);
        chk("ovr_pwr_hold", 64'(o_power), 64'd169);

        // reset while in S_SQIM discards the frame
        i_valid = 1'b1;
        i_re    = 18'sd3;
        i_im    = 18'sd4;
        tick();
        i_valid = 1'b0;
        tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(o_busy), 64'd0);
        chk("mid_rst_pwr", 64'(o_power), 64'd0);
        chk("mid_rst_pv", 64'(o_power_valid), 64'd0);
        pv_cyc = 0;
        repeat (2) begin
            tick();
            pv_cyc += int'(o_power_valid);
        end
        i_rst_n = 1'b1;
        repeat (3) begin
            tick();
            pv_cyc += int'(o_power_valid);
        end
        chk("mid_rst_no_pv", 64'(pv_cyc), 64'd0);
        frame("post_rst", 18'sd6, 18'sd8, 36'd100, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
